// File: rtl/collision_pkg.sv
// Shared types for the sprite/tile collision scanner: coordinate typedefs,
// side-bit positions in the result vector and the scan FSM states.
package collision_pkg;

  typedef logic [9:0] x_t;
  typedef logic [8:0] y_t;

  localparam int SIDE_DOWN  = 0;
  localparam int SIDE_UP    = 1;
  localparam int SIDE_RIGHT = 2;
  localparam int SIDE_LEFT  = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/collision_scan_if.sv
// Request/result and tile-table bus of the collision scanner.
// slave = scanner side, master = requester plus tile-table side.
// With COLLISION_HIT_IDX_EN the bus also carries hit_vld/hit_idx.
interface collision_scan_if
  import collision_pkg::*;
#(
  parameter int N_TILES = 16
);
  localparam int IDX_W = $clog2(N_TILES);

  logic             start;
  x_t               x_blue;
  y_t               y_blue;
  logic [IDX_W-1:0] tile_idx;
  x_t               tile_x;
  y_t               tile_y;
  logic             tile_vld;
  logic             busy;
  logic             done;
  logic [3:0]       is_Collision;
`ifdef COLLISION_HIT_IDX_EN
  logic             hit_vld;
  logic [IDX_W-1:0] hit_idx;

  modport slave (
    input  start, x_blue, y_blue, tile_x, tile_y, tile_vld,
    output tile_idx, busy, done, is_Collision, hit_vld, hit_idx
  );
  modport master (
    output start, x_blue, y_blue, tile_x, tile_y, tile_vld,
    input  tile_idx, busy, done, is_Collision, hit_vld, hit_idx
  );
`else
  modport slave (
    input  start, x_blue, y_blue, tile_x, tile_y, tile_vld,
    output tile_idx, busy, done, is_Collision
  );
  modport master (
    output start, x_blue, y_blue, tile_x, tile_y, tile_vld,
    input  tile_idx, busy, done, is_Collision
  );
`endif

endinterface

// File: rtl/collision_cmp.sv
// Combinational edge-contact test of one sprite against one tile.
// All sums are widened by one bit so nothing wraps; only additions and
// comparisons are used, so coordinates near the screen edge need no care.
module collision_cmp
  import collision_pkg::*;
#(
  parameter int SPR_W  = 23,
  parameter int SPR_H  = 45,
  parameter int TILE_W = 25,
  parameter int TILE_H = 24,
  parameter int MARGIN = 2
) (
  input  x_t         xs,
  input  y_t         ys,
  input  x_t         xt,
  input  y_t         yt,
  output logic [3:0] sides
);

  logic [10:0] xs_e, xt_e, xs_r, xt_m, xt_r1, xt_r;
  logic [9:0]  ys_e, yt_e, ys_b, ys_m, yt_b, yt_m;
  logic        x_win, y_win;

  assign xs_e  = {1'b0, xs};
  assign xt_e  = {1'b0, xt};
  assign xs_r  = xs_e + 11'(SPR_W);
  assign xt_m  = xt_e + 11'(MARGIN);
  assign xt_r1 = xt_e + 11'(TILE_W + 1);
  assign xt_r  = xt_e + 11'(TILE_W);

  assign ys_e  = {1'b0, ys};
  assign yt_e  = {1'b0, yt};
  assign ys_b  = ys_e + 10'(SPR_H);
  assign ys_m  = ys_e + 10'(MARGIN);
  assign yt_b  = yt_e + 10'(TILE_H);
  assign yt_m  = yt_e + 10'(MARGIN);

  // Overlap windows shrunk by MARGIN so corner-only contacts are dropped
  always_comb begin
    sides             = '0;
    x_win             = (xs_r > xt_m) && (xs_r < xt_r1);
    y_win             = (ys_m < yt_b) && (ys_b > yt_m);
    sides[SIDE_DOWN]  = x_win && (ys_b == yt_e);
    sides[SIDE_UP]    = x_win && (ys_e == yt_b);
    sides[SIDE_RIGHT] = y_win && (xs_r == xt_e);
    sides[SIDE_LEFT]  = y_win && (xs_e == xt_r);
  end

endmodule

// File: rtl/collision_scan.sv
// Collision scanner: on start, walks the N_TILES-entry tile table, tests
// the latched sprite against every valid tile and ORs the touched sides.
// The table has one cycle of read latency, so compares trail the address
// by one cycle (vld_pipe[0] = address issued, vld_pipe[1] = compare).
// Optional build macro COLLISION_HIT_IDX_EN adds hit_vld/hit_idx: the
// lowest-index valid tile with any side set.
module collision_scan
  import collision_pkg::*;
#(
  parameter int N_TILES = 16,
  parameter int SPR_W   = 23,
  parameter int SPR_H   = 45,
  parameter int TILE_W  = 25,
  parameter int TILE_H  = 24,
  parameter int MARGIN  = 2
) (
  input  logic             clk,
  input  logic             rst,
  collision_scan_if.slave  bus
);

  localparam int               IDX_W    = $clog2(N_TILES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_TILES - 1);

  state_t           state, state_nx;
  x_t               xs_q;
  y_t               ys_q;
  logic [IDX_W-1:0] idx_q;
  logic [1:0]       vld_pipe;
  logic             cmp_last_q;
  logic [3:0]       acc_q, side_q;
  logic [3:0]       tile_sides, hit_sides, acc_nx;

  collision_cmp #(
    .SPR_W (SPR_W),
    .SPR_H (SPR_H),
    .TILE_W(TILE_W),
    .TILE_H(TILE_H),
    .MARGIN(MARGIN)
  ) u_cmp (
    .xs   (xs_q),
    .ys   (ys_q),
    .xt   (bus.tile_x),
    .yt   (bus.tile_y),
    .sides(tile_sides)
  );

  assign hit_sides = (vld_pipe[1] && bus.tile_vld) ? tile_sides : 4'b0000;
  assign acc_nx    = acc_q | hit_sides;

  // Next state: leave SCAN once the last entry has been compared
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.start) state_nx = SCAN;
      SCAN:    if (vld_pipe[1] && cmp_last_q) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State, address walk, accumulator and published result
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      xs_q       <= '0;
      ys_q       <= '0;
      idx_q      <= '0;
      vld_pipe   <= '0;
      cmp_last_q <= 1'b0;
      acc_q      <= '0;
      side_q     <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (bus.start) begin
            xs_q       <= bus.x_blue;
            ys_q       <= bus.y_blue;
            idx_q      <= '0;
            acc_q      <= '0;
            vld_pipe   <= 2'b01;
            cmp_last_q <= 1'b0;
          end
        end
        SCAN: begin
          vld_pipe[1] <= vld_pipe[0];
          cmp_last_q  <= vld_pipe[0] && (idx_q == LAST_IDX);
          if (vld_pipe[0]) begin
            if (idx_q == LAST_IDX) vld_pipe[0] <= 1'b0;
            else                   idx_q       <= idx_q + IDX_W'(1);
          end
          acc_q <= acc_nx;
          // Result becomes visible together with done in the DONE cycle
          if (state_nx == DONE) side_q <= acc_nx;
        end
        default: vld_pipe <= '0;
      endcase
    end
  end

  assign bus.tile_idx     = idx_q;
  assign bus.busy         = (state != IDLE);
  assign bus.done         = (state == DONE);
  assign bus.is_Collision = side_q;

`ifdef COLLISION_HIT_IDX_EN
  logic [IDX_W-1:0] cmp_idx_q, first_idx_q, hit_idx_q;
  logic             first_vld_q, hit_vld_q, hit_now;

  assign hit_now = |hit_sides;

  // Remember the first matching entry; publish it alongside is_Collision
  always_ff @(posedge clk) begin
    if (rst) begin
      cmp_idx_q   <= '0;
      first_idx_q <= '0;
      first_vld_q <= 1'b0;
      hit_idx_q   <= '0;
      hit_vld_q   <= 1'b0;
    end else if (state == IDLE && bus.start) begin
      first_vld_q <= 1'b0;
      first_idx_q <= '0;
    end else if (state == SCAN) begin
      cmp_idx_q <= idx_q;
      if (hit_now && !first_vld_q) begin
        first_vld_q <= 1'b1;
        first_idx_q <= cmp_idx_q;
      end
      if (state_nx == DONE) begin
        hit_vld_q <= first_vld_q || hit_now;
        hit_idx_q <= first_vld_q ? first_idx_q : (hit_now ? cmp_idx_q : '0);
      end
    end
  end

  assign bus.hit_vld = hit_vld_q;
  assign bus.hit_idx = hit_idx_q;
`endif

endmodule

// File: tb/tb_collision_scan.sv
// Directed bench for collision_scan: a tile-table model answers reads one
// cycle late, expected results are queued at start and popped at done.
module tb_collision_scan;
  import collision_pkg::*;

  localparam int N     = 16;
  localparam int IDX_W = $clog2(N);

  typedef struct {
    logic [3:0]       sides;
    logic             hv;
    logic [IDX_W-1:0] hi;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   vecs = 0;
  int   errs = 0;
  exp_t sb[$];

  logic [9:0] mx[N];
  logic [8:0] my[N];
  logic       mv[N];

  always #5 clk = ~clk;

  collision_scan_if #(.N_TILES(N)) bus ();

  collision_scan #(.N_TILES(N)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Tile table with one cycle of read latency
  always_ff @(posedge clk) begin
    bus.tile_x   <= mx[bus.tile_idx];
    bus.tile_y   <= my[bus.tile_idx];
    bus.tile_vld <= mv[bus.tile_idx];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_tiles();
    for (int i = 0; i < N; i++) begin
      mx[i] = 10'd500; my[i] = 9'd400; mv[i] = 1'b0;
    end
  endtask

  task automatic put_tile(input int i, input int x, input int y, input logic v);
    mx[i] = 10'(x); my[i] = 9'(y); mv[i] = v;
  endtask

  // Reference contact test written directly on integers (no overflow)
  function automatic logic [3:0] model(input int xs, ys, xt, yt);
    logic [3:0] r;
    logic xw, yw;
    xw   = (xs + 23 >= xt + 3) && (xs + 23 <= xt + 25);
    yw   = (ys + 2 < yt + 24) && (ys + 45 >= yt + 3);
    r[0] = xw && (ys + 45 == yt);
    r[1] = xw && (ys == yt + 24);
    r[2] = yw && (xs + 23 == xt);
    r[3] = yw && (xs == xt + 25);
    return r;
  endfunction

  function automatic exp_t model_scan(input int xs, ys);
    exp_t e;
    logic [3:0] f;
    e.sides = '0; e.hv = 1'b0; e.hi = '0;
    for (int i = 0; i < N; i++) begin
      f = mv[i] ? model(xs, ys, int'(mx[i]), int'(my[i])) : 4'b0000;
      e.sides |= f;
      if (f != 0 && !e.hv) begin e.hv = 1'b1; e.hi = IDX_W'(i); end
    end
    return e;
  endfunction

  // One scan: start in cycle 0, optional extra start pulses (pa/pb) and an
  // optional reset pulse (ra), then observe 30 cycles.
  task automatic run_scan(input int xs, ys, input exp_t e, input int pa, pb, ra);
    int   done_cnt = 0;
    int   done_cyc = 0;
    logic busy_ok  = 1'b1;
    logic exp_busy;
    exp_t x;
    if (ra == 0) sb.push_back(e);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.x_blue = 10'(xs); bus.y_blue = 9'(ys);
    @(negedge clk);
    chk("busy_start_cycle", bus.busy, 0);
    @(posedge clk); #1;
    bus.start = 1'b0; bus.x_blue = '0; bus.y_blue = '0;
    for (int c = 1; c <= 30; c++) begin
      bus.start = (c == pa) || (c == pb);
      rst       = (ra != 0) && (c == ra);
      @(negedge clk);
      exp_busy = (ra == 0) ? (c <= N + 2) : (c <= ra);
      if (bus.busy !== exp_busy) busy_ok = 1'b0;
      if (bus.done === 1'b1) begin
        done_cnt++;
        if (done_cyc == 0) done_cyc = c;
        chk("sb_has_entry", (sb.size() != 0), 1);
        if (sb.size() != 0) begin
          x = sb.pop_front();
          chk("sides", bus.is_Collision, x.sides);
`ifdef COLLISION_HIT_IDX_EN
          chk("hit_vld", bus.hit_vld, x.hv);
          if (x.hv) chk("hit_idx", bus.hit_idx, x.hi);
`endif
        end
      end
      if (c == 30 && ra == 0) chk("sides_hold", bus.is_Collision, e.sides);
      @(posedge clk); #1;
    end
    bus.start = 1'b0; rst = 1'b0;
    chk("busy_window", busy_ok, 1);
    if (ra == 0) begin
      chk("done_count", done_cnt, 1);
      chk("done_latency", done_cyc, N + 2);
    end else begin
      chk("rst_no_done", done_cnt, 0);
      chk("rst_sides", bus.is_Collision, 0);
      chk("rst_idx", bus.tile_idx, 0);
`ifdef COLLISION_HIT_IDX_EN
      chk("rst_hit_vld", bus.hit_vld, 0);
`endif
    end
  endtask

  initial begin
    exp_t e;
    int   xs, ys, k, j;
    rst = 1'b1; bus.start = 1'b0; bus.x_blue = '0; bus.y_blue = '0;
    clear_tiles();
    repeat (3) @(posedge clk);
    #1;
    // reset wins over a simultaneous start
    bus.start = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; bus.start = 1'b0;
    @(negedge clk);
    chk("reset_busy", bus.busy, 0);
    chk("reset_done", bus.done, 0);
    chk("reset_sides", bus.is_Collision, 0);
    chk("reset_idx", bus.tile_idx, 0);
`ifdef COLLISION_HIT_IDX_EN
    chk("reset_hit_vld", bus.hit_vld, 0);
    chk("reset_hit_idx", bus.hit_idx, 0);
`endif

    // single tile touching the sprite's bottom edge
    clear_tiles(); put_tile(0, 110, 100, 1'b1);
    e = '{4'b0001, 1'b1, IDX_W'(0)};
    run_scan(100, 55, e, 0, 0, 0);

    // up/right/left from three tiles; an invalid matching tile is ignored
    clear_tiles();
    put_tile(1, 110, 100, 1'b0);
    put_tile(3, 110, 31, 1'b1);
    put_tile(7, 123, 60, 1'b1);
    put_tile(12, 75, 60, 1'b1);
    e = '{4'b1110, 1'b1, IDX_W'(3)};
    run_scan(100, 55, e, 0, 0, 0);

    // corner contact inside the margin
    clear_tiles(); put_tile(5, 79, 100, 1'b1);
    e = '{4'b0000, 1'b0, IDX_W'(0)};
    run_scan(100, 55, e, 0, 0, 0);

    // only the last table entry matches
    clear_tiles(); put_tile(N - 1, 123, 60, 1'b1);
    e = '{4'b0100, 1'b1, IDX_W'(N - 1)};
    run_scan(100, 55, e, 0, 0, 0);

    // starts while busy (mid-scan and in the done cycle) are ignored
    clear_tiles(); put_tile(0, 110, 100, 1'b1);
    e = '{4'b0001, 1'b1, IDX_W'(0)};
    run_scan(100, 55, e, 3, N + 2, 0);
    run_scan(100, 55, e, 0, 0, 0);

    // reset mid-scan aborts; the next scan runs normally
    clear_tiles();
    put_tile(3, 110, 31, 1'b1);
    put_tile(7, 123, 60, 1'b1);
    put_tile(12, 75, 60, 1'b1);
    run_scan(100, 55, e, 0, 0, 8);
    e = '{4'b1110, 1'b1, IDX_W'(3)};
    run_scan(100, 55, e, 0, 0, 0);

    // far screen corner against a tile at the origin: no wrap-around
    clear_tiles();
    for (int i = 0; i < N; i++) put_tile(i, 0, 0, 1'b1);
    e = '{4'b0000, 1'b0, IDX_W'(0)};
    run_scan(1020, 500, e, 0, 0, 0);

    // random tables placed around exact contact lines
    for (int r = 0; r < 4; r++) begin
      xs = $urandom_range(40, 900);
      ys = $urandom_range(40, 400);
      clear_tiles();
      for (int i = 0; i < N; i++) begin
        k = $urandom_range(0, 3);
        j = $urandom_range(0, 60) - 30;
        case (k)
          0: put_tile(i, xs + j, ys + 45, $urandom_range(0, 3) != 0);
          1: put_tile(i, xs + j, ys - 24, $urandom_range(0, 3) != 0);
          2: put_tile(i, xs + 23, ys + j, $urandom_range(0, 3) != 0);
          default: put_tile(i, xs - 25, ys + j, $urandom_range(0, 3) != 0);
        endcase
      end
      e = model_scan(xs, ys);
      run_scan(xs, ys, e, 0, 0, 0);
    end

    chk("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/collision_scan.md
COLLISION_SCAN -- requirements
Module: collision_scan

Interface
REQ-001 The parameter N_TILES SHALL default to 16 and set the number of tile-table entries scanned per request; the legal range is 2..256.
REQ-002 The parameter SPR_W SHALL default to 23 and set the sprite width in pixels.
REQ-003 The parameter SPR_H SHALL default to 45 and set the sprite height in pixels.
REQ-004 The parameter TILE_W SHALL default to 25 and set the tile width in pixels.
REQ-005 The parameter TILE_H SHALL default to 24 and set the tile height in pixels.
REQ-006 The parameter MARGIN SHALL default to 2 and set the corner-exclusion margin in pixels.
REQ-007 The port clk SHALL be an input, 1 bit wide, and is the single clock; all logic is on its rising edge.
REQ-008 The port rst SHALL be an input, 1 bit wide, and is the reset; it is synchronous and active-high.
REQ-009 The port start SHALL be an input, 1 bit wide, and requests a scan.
REQ-010 The port x_blue SHALL be an input, 10 bits wide, and carries the sprite top-left x.
REQ-011 The port y_blue SHALL be an input, 9 bits wide, and carries the sprite top-left y.
REQ-012 The port tile_idx SHALL be an output, $clog2(N_TILES) bits wide, and carries the tile-table read address.
REQ-013 The port tile_x SHALL be an input, 10 bits wide, and carries the tile top-left x, valid one cycle after tile_idx.
REQ-014 The port tile_y SHALL be an input, 9 bits wide, and carries the tile top-left y, valid one cycle after tile_idx.
REQ-015 The port tile_vld SHALL be an input, 1 bit wide; when 0 the entry is unused and is skipped.
REQ-016 The port busy SHALL be an output, 1 bit wide, and is high while a scan is in progress.
REQ-017 The port done SHALL be an output, 1 bit wide, and is a one-cycle pulse when a result is published.
REQ-018 The port is_Collision SHALL be an output, 4 bits wide, and carries the published sides: bit0 down, bit1 up, bit2 right, bit3 left.

Function
REQ-019 The state machine SHALL have three states: IDLE, SCAN and DONE.
REQ-020 In IDLE, start=1 SHALL latch x_blue and y_blue, clear the side accumulator, set tile_idx=0 and move to SCAN.
REQ-021 In SCAN, tile_idx SHALL increment by 1 each cycle up to N_TILES-1, and the tile data returned for each address SHALL be compared one cycle later.
REQ-022 After the compare of entry N_TILES-1, the state machine SHALL go to DONE.
REQ-023 DONE SHALL copy the accumulator to is_Collision, pulse done for one cycle and return to IDLE.
REQ-024 Latency SHALL be fixed: done is high exactly N_TILES+2 cycles after the start cycle, and busy is high from the cycle after start through the done cycle.
REQ-025 A start asserted while busy=1 SHALL be ignored, including start asserted in the done cycle.
REQ-026 is_Collision SHALL hold its value between scans and change only in the DONE state or on reset.
REQ-027 Per-entry side flags SHALL be OR-accumulated across the scan, and an entry with tile_vld=0 SHALL contribute nothing.
REQ-028 Down: the down flag SHALL be set when xs+SPR_W > xt+MARGIN, xs+SPR_W < xt+TILE_W+1, and ys+SPR_H == yt.
REQ-029 Up: the up flag SHALL be set when the x window of REQ-028 holds and ys == yt+TILE_H.
REQ-030 Right: the right flag SHALL be set when xs+SPR_W == xt, ys+MARGIN < yt+TILE_H, and ys+SPR_H > yt+MARGIN.
REQ-031 Left: the left flag SHALL be set when xs == xt+TILE_W and the y window of REQ-030 holds.
REQ-032 All sums SHALL be evaluated zero-extended to 11 bits for x and 10 bits for y, so no wrap-around occurs, and subtraction SHALL NOT be used.
REQ-033 Coordinates SHALL be taken as-is: a tile at the screen edge is handled with no special case, and x=1023 or y=511 produce no false match through overflow.

Reset
REQ-034 When rst=1, the state machine SHALL go to IDLE and set tile_idx=0, busy=0, done=0, is_Collision=0 and accumulator=0.
REQ-035 A reset during SCAN SHALL abort the scan, publish no result and assert no done.
REQ-036 rst SHALL take priority over start in the same cycle.

Configuration
REQ-037 With COLLISION_HIT_IDX_EN defined, the block SHALL add an output hit_vld (1 bit) and an output hit_idx ($clog2(N_TILES) bits) that carry the lowest-index valid tile with any side set, published in DONE.
REQ-038 hit_vld and hit_idx SHALL reset to 0, and hit_vld SHALL be 0 when no tile matched.
REQ-039 Without COLLISION_HIT_IDX_EN, the ports hit_vld and hit_idx and their logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-040 The shared package collision_pkg SHALL hold the coordinate typedefs (10-bit x, 9-bit y), the side-bit index constants (SIDE_DOWN=0, SIDE_UP=1, SIDE_RIGHT=2, SIDE_LEFT=3) and the state enum.
REQ-041 A single combinational sub-module collision_cmp SHALL implement REQ-028..REQ-033 for one sprite/tile pair and return 4 bits.

Verification
REQ-042 Sprite (100,55) with tile0 (110,100) valid and the others invalid -> after 18 cycles (N_TILES=16), done=1 and is_Collision=4'b0001.
REQ-043 Sprite (100,55) with tiles (110,31), (123,60) and (75,60) valid -> is_Collision=4'b1110, and with the hit-index macro enabled hit_idx equals the lowest of the three indices.
REQ-044 Sprite (100,55) with tile (79,100), where the corner lies inside the margin -> is_Collision=4'b0000 and hit_vld=0.
REQ-045 start pulsed again at cycles 3 and 18 of a scan -> exactly one done and no restart; a subsequent start in IDLE is accepted.
REQ-046 rst asserted at cycle 8 of a scan -> busy=0, is_Collision=0 and done never asserts; a new scan afterwards completes normally.
REQ-047 Sprite (1020,500) with a tile at (0,0) -> no flag is set, which checks that there is no wrap-around.
